// File: rtl/ld_ctrl.sv
// ld_ctrl: handshaked load sequencer between the instruction decoder and the
// register file / data memory.
//
// Accepts one load instruction at a time on ins/ins_valid/ins_ready. A memory
// load issues a read on the data-memory port (mem_addr/mem_rd) and waits for
// mem_ack. An immediate load merges an 8-bit immediate into one byte of the
// destination register. The result is written through wr_en/wr_sel/wr_data,
// and done pulses for one cycle when the write happens.
//
// Optional feature: define LD_CTRL_TIMEOUT_EN to abandon a read that has not
// been acknowledged within TIMEOUT cycles. An abandoned read pulses err. When
// the macro is undefined, the read waits indefinitely and err is tied to 0.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   ins, ins_valid        load instruction and its valid strobe
//   ins_ready             controller idle and able to accept ins
//   reg_a, reg_b          current register contents (immediate merge)
//   mem_addr, mem_rd      data-memory read address and request
//   mem_data, mem_ack     read data and acknowledge
//   wr_en, wr_sel         register write strobe and destination (0=A, 1=B)
//   wr_data               register write data
//   done, err             one-cycle pulses: load retired / load abandoned
module ld_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ins,
   input  logic        ins_valid,
   output logic        ins_ready,
   input  logic [15:0] reg_a,
   input  logic [15:0] reg_b,
   output logic [7:0]  mem_addr,
   output logic        mem_rd,
   input  logic [15:0] mem_data,
   input  logic        mem_ack,
   output logic        wr_en,
   output logic        wr_sel,
   output logic [15:0] wr_data,
   output logic        done,
   output logic        err
);

   localparam int unsigned CNT_W  = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t      state;
   logic [15:0] ins_q;
   logic [15:0] data_q;
   logic [15:0] sel_reg;
   logic [15:0] imm_data;

`ifdef LD_CTRL_TIMEOUT_EN
   logic [CNT_W-1:0] wait_cnt;
`endif

   // Sequencer: state, latched instruction/data and registered strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ins_q     <= '0;
         data_q    <= '0;
         ins_ready <= 1'b1;
         mem_rd    <= 1'b0;
         wr_en     <= 1'b0;
         wr_sel    <= 1'b0;
         done      <= 1'b0;
`ifdef LD_CTRL_TIMEOUT_EN
         err       <= 1'b0;
         wait_cnt  <= '0;
`endif
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
`ifdef LD_CTRL_TIMEOUT_EN
         err   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (ins_valid) begin
                  ins_q     <= ins;
                  ins_ready <= 1'b0;
                  if (ins[10]) begin
                     state  <= WRITE;
                     wr_en  <= 1'b1;
                     done   <= 1'b1;
                     wr_sel <= ins[11];
                  end else begin
                     state  <= REQ;
                     mem_rd <= 1'b1;
`ifdef LD_CTRL_TIMEOUT_EN
                     wait_cnt <= '0;
`endif
                  end
               end
            end
            REQ: begin
               // An ack always wins, even in the cycle the wait limit is hit.
               if (mem_ack) begin
                  data_q <= mem_data;
                  mem_rd <= 1'b0;
                  state  <= WRITE;
                  wr_en  <= 1'b1;
                  done   <= 1'b1;
                  wr_sel <= ins_q[11];
               end
`ifdef LD_CTRL_TIMEOUT_EN
               else if (wait_cnt == CNT_LAST) begin
                  mem_rd    <= 1'b0;
                  state     <= IDLE;
                  ins_ready <= 1'b1;
                  err       <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
`endif
            end
            WRITE: begin
               state     <= IDLE;
               ins_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               ins_ready <= 1'b1;
               mem_rd    <= 1'b0;
            end
         endcase
      end
   end

`ifndef LD_CTRL_TIMEOUT_EN
   assign err = 1'b0;
`endif

   // Immediate merge uses the destination register as seen in the WRITE cycle.
   assign sel_reg  = ins_q[11] ? reg_b : reg_a;
   assign imm_data = ins_q[9] ? {ins_q[7:0], sel_reg[7:0]}
                              : {sel_reg[15:8], ins_q[7:0]};

   assign wr_data  = (state == WRITE) ? (ins_q[10] ? imm_data : data_q) : 16'h0000;
   assign mem_addr = ins_q[7:0];

   // Instruction bits with no function here, and the limit when unused.
   logic unused_bits;
   assign unused_bits = ^{ins_q[15:12], ins_q[8], CNT_LAST};

endmodule

// File: tb/tb_ld_ctrl.sv
// Self-checking bench for ld_ctrl: directed cases plus randomized loads,
// with a queue-based scoreboard checked by an independent write monitor.
module tb_ld_ctrl;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] ins = '0;
   logic        ins_valid = 1'b0;
   logic        ins_ready;
   logic [15:0] reg_a = '0;
   logic [15:0] reg_b = '0;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [15:0] mem_data = '0;
   logic        mem_ack = 1'b0;
   logic        wr_en;
   logic        wr_sel;
   logic [15:0] wr_data;
   logic        done;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;
   logic [16:0] exp_q[$];
   logic        prev_wr = 1'b0;

   ld_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid),
      .ins_ready(ins_ready), .reg_a(reg_a), .reg_b(reg_b),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
      .mem_ack(mem_ack), .wr_en(wr_en), .wr_sel(wr_sel),
      .wr_data(wr_data), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: what a load must write, from the instruction fields alone.
   function automatic logic [16:0] model(input logic [15:0] i, input logic [15:0] ra,
                                         input logic [15:0] rb, input logic [15:0] md);
      logic [15:0] r;
      logic [15:0] res;
      r = i[11] ? rb : ra;
      if (!i[10])     res = md;
      else if (i[9])  res = {i[7:0], r[7:0]};
      else            res = {r[15:8], i[7:0]};
      return {i[11], res};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 32'(wr_en), 32'd0);
            end else begin
               logic [16:0] e;
               e = exp_q.pop_front();
               chk("wr_sel", 32'(wr_sel), 32'(e[16]));
               chk("wr_data", 32'(wr_data), 32'(e[15:0]));
            end
            if (prev_wr) chk("wr_en_single", 32'(prev_wr), 32'd0);
         end
         if (wr_en || done) chk("done_vs_wr_en", 32'(done), 32'(wr_en));
         if (err) chk("err_not_done", 32'(done), 32'd0);
         prev_wr <= wr_en;
      end else begin
         prev_wr <= 1'b0;
      end
   end

   // One complete load; waits = cycles in REQ before the ack cycle.
   task automatic do_load(input logic [15:0] i, input logic [15:0] ra, input logic [15:0] rb,
                          input int waits, input logic [15:0] md);
      chk("ins_ready_idle", 32'(ins_ready), 32'd1);
      ins = i; ins_valid = 1'b1; reg_a = ra; reg_b = rb;
      exp_q.push_back(model(i, ra, rb, md));
      step();
      ins_valid = 1'b0;
      if (!i[10]) begin
         for (int k = 0; k < waits; k++) begin
            chk("mem_rd_wait", 32'(mem_rd), 32'd1);
            chk("mem_addr_wait", 32'(mem_addr), 32'(i[7:0]));
            chk("ins_ready_req", 32'(ins_ready), 32'd0);
            ins_valid = 1'b1;
            ins = 16'($urandom);
            mem_data = 16'($urandom);
            step();
         end
         chk("mem_rd_ack", 32'(mem_rd), 32'd1);
         chk("mem_addr_ack", 32'(mem_addr), 32'(i[7:0]));
         ins_valid = 1'b0;
         mem_ack = 1'b1;
         mem_data = md;
         step();
         mem_ack = 1'b0;
         mem_data = 16'($urandom);
      end
      chk("wr_en_write", 32'(wr_en), 32'd1);
      chk("mem_rd_write", 32'(mem_rd), 32'd0);
      chk("ins_ready_write", 32'(ins_ready), 32'd0);
      step();
      chk("wr_en_after", 32'(wr_en), 32'd0);
      chk("ins_ready_after", 32'(ins_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ri;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ins_ready", 32'(ins_ready), 32'd1);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_sel", 32'(wr_sel), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      step();

      do_load(16'h0412, 16'hABCD, 16'h0000, 0, 16'h0000);
      do_load(16'h0E5A, 16'h0000, 16'h1234, 0, 16'h0000);
      do_load(16'h0830, 16'h1111, 16'h2222, 3, 16'hBEEF);
      do_load(16'h0077, 16'h0000, 16'h0000, 0, 16'hC0DE);

      // Back-to-back immediates with ins_valid held high.
      chk("b2b_ready", 32'(ins_ready), 32'd1);
      reg_a = 16'h5566; reg_b = 16'h7788;
      ins = 16'h0601; ins_valid = 1'b1;
      exp_q.push_back(model(16'h0601, reg_a, reg_b, 16'h0));
      step();
      chk("b2b_wr1", 32'(wr_en), 32'd1);
      chk("b2b_busy", 32'(ins_ready), 32'd0);
      ins = 16'h0C02;
      exp_q.push_back(model(16'h0C02, reg_a, reg_b, 16'h0));
      step();
      chk("b2b_accept2", 32'(ins_ready), 32'd1);
      chk("b2b_gap", 32'(wr_en), 32'd0);
      step();
      ins_valid = 1'b0;
      chk("b2b_wr2", 32'(wr_en), 32'd1);
      step();
      chk("b2b_idle", 32'(ins_ready), 32'd1);

      // Reset in the middle of a read: abandon immediately, ignore late ack.
      ins = 16'h0055; ins_valid = 1'b1;
      step();
      ins_valid = 1'b0;
      chk("mid_mem_rd", 32'(mem_rd), 32'd1);
      step();
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("mid_rst_ready", 32'(ins_ready), 32'd1);
      chk("mid_rst_addr", 32'(mem_addr), 32'd0);
      step();
      rst = 1'b0;
      mem_ack = 1'b1; mem_data = 16'hDEAD;
      step();
      mem_ack = 1'b0;
      chk("late_ack_wr", 32'(wr_en), 32'd0);
      chk("late_ack_rd", 32'(mem_rd), 32'd0);
      chk("late_ack_ready", 32'(ins_ready), 32'd1);
      step();

`ifdef LD_CTRL_TIMEOUT_EN
      // No ack: TO request cycles, then err in the first idle cycle.
      ins = 16'h0042; ins_valid = 1'b1;
      step();
      ins_valid = 1'b0;
      for (int k = 0; k < int'(TO); k++) begin
         chk("to_mem_rd", 32'(mem_rd), 32'd1);
         chk("to_no_err", 32'(err), 32'd0);
         step();
      end
      chk("to_err", 32'(err), 32'd1);
      chk("to_mem_rd_drop", 32'(mem_rd), 32'd0);
      chk("to_wr_en", 32'(wr_en), 32'd0);
      chk("to_ready", 32'(ins_ready), 32'd1);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("to_err_pulse", 32'(err), 32'd0);
      chk("to_late_wr", 32'(wr_en), 32'd0);
      step();
      // Ack in the last allowed cycle still completes normally.
      do_load(16'h0099, 16'h0, 16'h0, int'(TO) - 1, 16'h4321);
      chk("to_edge_err", 32'(err), 32'd0);
`endif

      for (int n = 0; n < 40; n++) begin
         ri = 16'($urandom);
         do_load(ri, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 16'($urandom));
      end

      step();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
